set_assoc_branch_target_buffer: RTL and testbench



---
 rtl/set_assoc_branch_target_buffer.sv | 169 ++++++++++++++++
 tb/tb_set_assoc_branch_target_buffer.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/set_assoc_branch_target_buffer.sv
// N-way set-associative branch target buffer: zero-latency lookup, saturating
// direction counters, true-LRU replacement, synchronous flush and async reset.
module set_assoc_branch_target_buffer #(
    parameter int ADDR_W    = 32,
    parameter int SETS_LOG2 = 4,
    parameter int WAYS      = 2,
    parameter int CTR_W     = 2
) (
    input  logic              btb_clk,
    input  logic              btb_reset,
    input  logic              btb_flush,
    input  logic [ADDR_W-1:0] btb_pc,
    output logic              btb_hit,
    output logic              btb_valid_prediction,
    output logic [ADDR_W-1:0] btb_target,
    input  logic              btb_write,
    input  logic [ADDR_W-1:0] btb_new_pc,
    input  logic              btb_branch_taken,
    input  logic [ADDR_W-1:0] btb_data
);

    localparam int SETS  = 1 << SETS_LOG2;
    localparam int TAG_W = ADDR_W - SETS_LOG2 - 2;
    // A single-way table still keeps a 1-bit age field that is permanently 0.
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [WAY_W-1:0] AGE_OLDEST = WAY_W'(WAYS - 1);
    localparam logic [CTR_W-1:0] CTR_MAX    = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_WEAK   = CTR_W'(32'd1 << (CTR_W - 1));

    logic              valid_r  [SETS][WAYS];
    logic [TAG_W-1:0]  tag_r    [SETS][WAYS];
    logic [ADDR_W-1:0] target_r [SETS][WAYS];
    logic [CTR_W-1:0]  ctr_r    [SETS][WAYS];
    logic [WAY_W-1:0]  age_r    [SETS][WAYS];

    logic [SETS_LOG2-1:0] rd_idx_s;
    logic [TAG_W-1:0]     rd_tag_s;
    logic                 rd_hit_s;
    logic [WAY_W-1:0]     rd_way_s;

    logic [SETS_LOG2-1:0] wr_idx_s;
    logic [TAG_W-1:0]     wr_tag_s;
    logic                 wr_hit_s;
    logic [WAY_W-1:0]     wr_hit_way_s;
    logic                 wr_inv_found_s;
    logic [WAY_W-1:0]     wr_inv_way_s;
    logic [WAY_W-1:0]     wr_victim_s;
    logic [WAY_W-1:0]     wr_way_s;
    logic                 wr_touch_s;
    logic [CTR_W-1:0]     ctr_old_s;
    logic [CTR_W-1:0]     ctr_next_s;
    logic [ADDR_W-1:0]    target_next_s;
    logic [WAY_W-1:0]     age_next_s [WAYS];

    assign rd_idx_s = btb_pc[SETS_LOG2+1:2];
    assign rd_tag_s = btb_pc[ADDR_W-1:SETS_LOG2+2];
    assign wr_idx_s = btb_new_pc[SETS_LOG2+1:2];
    assign wr_tag_s = btb_new_pc[ADDR_W-1:SETS_LOG2+2];

    // Lookup tag match; scanning downwards lets the lowest matching way win.
    always_comb begin
        rd_hit_s = 1'b0;
        rd_way_s = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_r[rd_idx_s][w] && (tag_r[rd_idx_s][w] == rd_tag_s)) begin
                rd_hit_s = 1'b1;
                rd_way_s = WAY_W'(w);
            end else begin
                rd_hit_s = rd_hit_s;
            end
        end
    end

    assign btb_hit              = rd_hit_s;
    assign btb_valid_prediction = rd_hit_s & ctr_r[rd_idx_s][rd_way_s][CTR_W-1];
    assign btb_target           = rd_hit_s ? target_r[rd_idx_s][rd_way_s] : {ADDR_W{1'b0}};

    // Update-side hit, lowest invalid way, and LRU victim of the written set.
    always_comb begin
        wr_hit_s       = 1'b0;
        wr_hit_way_s   = '0;
        wr_inv_found_s = 1'b0;
        wr_inv_way_s   = '0;
        wr_victim_s    = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_r[wr_idx_s][w] && (tag_r[wr_idx_s][w] == wr_tag_s)) begin
                wr_hit_s     = 1'b1;
                wr_hit_way_s = WAY_W'(w);
            end else begin
                wr_hit_s = wr_hit_s;
            end
            if (!valid_r[wr_idx_s][w]) begin
                wr_inv_found_s = 1'b1;
                wr_inv_way_s   = WAY_W'(w);
            end else begin
                wr_inv_found_s = wr_inv_found_s;
            end
            if (age_r[wr_idx_s][w] == AGE_OLDEST) begin
                wr_victim_s = WAY_W'(w);
            end else begin
                wr_victim_s = wr_victim_s;
            end
        end
    end

    // Choose the written way and compute its next counter, target and set ages.
    always_comb begin
        wr_touch_s = btb_write & (wr_hit_s | btb_branch_taken);
        if (wr_hit_s) begin
            wr_way_s = wr_hit_way_s;
        end else if (wr_inv_found_s) begin
            wr_way_s = wr_inv_way_s;
        end else begin
            wr_way_s = wr_victim_s;
        end
        ctr_old_s = ctr_r[wr_idx_s][wr_way_s];
        if (!wr_hit_s) begin
            ctr_next_s = CTR_WEAK;
        end else if (btb_branch_taken) begin
            ctr_next_s = (ctr_old_s == CTR_MAX) ? ctr_old_s : ctr_old_s + CTR_W'(1);
        end else begin
            ctr_next_s = (ctr_old_s == {CTR_W{1'b0}}) ? ctr_old_s : ctr_old_s - CTR_W'(1);
        end
        target_next_s = btb_branch_taken ? btb_data : target_r[wr_idx_s][wr_way_s];
        for (int v = 0; v < WAYS; v++) begin
            if (WAY_W'(v) == wr_way_s) begin
                age_next_s[v] = '0;
            end else if (age_r[wr_idx_s][v] < age_r[wr_idx_s][wr_way_s]) begin
                age_next_s[v] = age_r[wr_idx_s][v] + WAY_W'(1);
            end else begin
                age_next_s[v] = age_r[wr_idx_s][v];
            end
        end
    end

    // Table state: async reset, flush beats write, then resolved-branch update.
    always_ff @(posedge btb_clk or posedge btb_reset) begin
        if (btb_reset) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_r[s][w]  <= 1'b0;
                    tag_r[s][w]    <= '0;
                    target_r[s][w] <= '0;
                    ctr_r[s][w]    <= '0;
                    age_r[s][w]    <= WAY_W'(w);
                end
            end
        end else if (btb_flush) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    valid_r[s][w]  <= 1'b0;
                    tag_r[s][w]    <= '0;
                    target_r[s][w] <= '0;
                    ctr_r[s][w]    <= '0;
                    age_r[s][w]    <= WAY_W'(w);
                end
            end
        end else if (wr_touch_s) begin
            valid_r[wr_idx_s][wr_way_s]  <= 1'b1;
            tag_r[wr_idx_s][wr_way_s]    <= wr_tag_s;
            target_r[wr_idx_s][wr_way_s] <= target_next_s;
            ctr_r[wr_idx_s][wr_way_s]    <= ctr_next_s;
            for (int v = 0; v < WAYS; v++) begin
                age_r[wr_idx_s][v] <= age_next_s[v];
            end
        end
    end

endmodule

// File: tb/tb_set_assoc_branch_target_buffer.sv
// Directed table-driven bench for the set-associative BTB (default parameters),
// plus hand-written reset sequences.
module tb_set_assoc_branch_target_buffer;

    logic        clk_s = 1'b0;
    logic        rst_s;
    logic        flush_s;
    logic [31:0] pc_s;
    logic        hit_s;
    logic        vp_s;
    logic [31:0] tgt_s;
    logic        wr_s;
    logic [31:0] npc_s;
    logic        taken_s;
    logic [31:0] data_s;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        flush;
        logic        wr;
        logic [31:0] npc;
        logic        taken;
        logic [31:0] data;
        logic [31:0] pc;
        logic        exp_hit;
        logic        exp_vp;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs[$];

    set_assoc_branch_target_buffer dut (
        .btb_clk              (clk_s),
        .btb_reset            (rst_s),
        .btb_flush            (flush_s),
        .btb_pc               (pc_s),
        .btb_hit              (hit_s),
        .btb_valid_prediction (vp_s),
        .btb_target           (tgt_s),
        .btb_write            (wr_s),
        .btb_new_pc           (npc_s),
        .btb_branch_taken     (taken_s),
        .btb_data             (data_s)
    );

    always #5 clk_s = ~clk_s;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic fl, input logic wr, input logic [31:0] npc, input logic tk,
                       input logic [31:0] data, input logic [31:0] pc,
                       input logic eh, input logic ev, input logic [31:0] et);
        vec_t v;
        v.flush = fl; v.wr = wr; v.npc = npc; v.taken = tk; v.data = data;
        v.pc = pc; v.exp_hit = eh; v.exp_vp = ev; v.exp_tgt = et;
        vecs.push_back(v);
    endtask

    task automatic check_out(input string name, input int idx, input logic eh, input logic ev, input logic [31:0] et);
        chk({name, ".hit"}, idx, {31'd0, hit_s}, {31'd0, eh});
        chk({name, ".vp"}, idx, {31'd0, vp_s}, {31'd0, ev});
        chk({name, ".target"}, idx, tgt_s, et);
    endtask

    initial begin
        rst_s = 1'b1; flush_s = 1'b0; pc_s = 32'h0; wr_s = 1'b0;
        npc_s = 32'h0; taken_s = 1'b0; data_s = 32'h0;

        // Each vector: lookup sees pre-edge state; the write lands at the next edge.
        //   flush  wr    npc       tk    data           pc        hit   vp    target
        add(1'b0, 1'b0, 32'h004, 1'b0, 32'h0,         32'h004, 1'b0, 1'b0, 32'h0);         // 0 empty
        add(1'b0, 1'b1, 32'h004, 1'b1, 32'hDEADBEEF,  32'h004, 1'b0, 1'b0, 32'h0);         // 1 no bypass
        add(1'b0, 1'b1, 32'h004, 1'b0, 32'h0,         32'h004, 1'b1, 1'b1, 32'hDEADBEEF);  // 2 ctr 2 -> 1
        add(1'b0, 1'b1, 32'h004, 1'b0, 32'h0,         32'h004, 1'b1, 1'b0, 32'hDEADBEEF);  // 3 ctr 1 -> 0
        add(1'b0, 1'b1, 32'h004, 1'b0, 32'h0,         32'h004, 1'b1, 1'b0, 32'hDEADBEEF);  // 4 ctr 0 sat
        add(1'b0, 1'b1, 32'h004, 1'b1, 32'hFEEDBEEF,  32'h004, 1'b1, 1'b0, 32'hDEADBEEF);  // 5 ctr -> 1
        add(1'b0, 1'b1, 32'h004, 1'b1, 32'hFEEDBEEF,  32'h004, 1'b1, 1'b0, 32'hFEEDBEEF);  // 6 ctr -> 2
        add(1'b0, 1'b1, 32'h004, 1'b1, 32'hFEEDBEEF,  32'h004, 1'b1, 1'b1, 32'hFEEDBEEF);  // 7 ctr -> 3
        add(1'b0, 1'b1, 32'h004, 1'b1, 32'hFEEDBEEF,  32'h004, 1'b1, 1'b1, 32'hFEEDBEEF);  // 8 ctr 3 sat
        add(1'b0, 1'b1, 32'h004, 1'b0, 32'h0,         32'h004, 1'b1, 1'b1, 32'hFEEDBEEF);  // 9 ctr -> 2
        add(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h004, 1'b1, 1'b1, 32'hFEEDBEEF);  // 10
        add(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         32'h004, 1'b1, 1'b1, 32'hFEEDBEEF);  // 11 flush
        add(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h004, 1'b0, 1'b0, 32'h0);         // 12
        add(1'b0, 1'b1, 32'h004, 1'b1, 32'hA,         32'h004, 1'b0, 1'b0, 32'h0);         // 13 alloc w0
        add(1'b0, 1'b1, 32'h044, 1'b1, 32'hB,         32'h004, 1'b1, 1'b1, 32'hA);         // 14 alloc w1
        add(1'b0, 1'b1, 32'h004, 1'b1, 32'hA,         32'h044, 1'b1, 1'b1, 32'hB);         // 15 touch w0
        add(1'b0, 1'b1, 32'h084, 1'b1, 32'hC,         32'h004, 1'b1, 1'b1, 32'hA);         // 16 evict 0x44
        add(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h044, 1'b0, 1'b0, 32'h0);         // 17
        add(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h004, 1'b1, 1'b1, 32'hA);         // 18
        add(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h084, 1'b1, 1'b1, 32'hC);         // 19
        add(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h087, 1'b1, 1'b1, 32'hC);         // 20 PC[1:0] ignored
        add(1'b1, 1'b0, 32'h0,   1'b0, 32'h0,         32'h0,   1'b0, 1'b0, 32'h0);         // 21 flush
        add(1'b0, 1'b1, 32'h104, 1'b0, 32'h55,        32'h104, 1'b0, 1'b0, 32'h0);         // 22 NT miss
        add(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h104, 1'b0, 1'b0, 32'h0);         // 23 no alloc
        add(1'b0, 1'b1, 32'h004, 1'b1, 32'h1,         32'h104, 1'b0, 1'b0, 32'h0);         // 24
        add(1'b0, 1'b1, 32'h000, 1'b1, 32'h5,         32'h004, 1'b1, 1'b1, 32'h1);         // 25 set 0
        add(1'b1, 1'b1, 32'h008, 1'b1, 32'h8,         32'h000, 1'b1, 1'b1, 32'h5);         // 26 flush+write
        add(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h008, 1'b0, 1'b0, 32'h0);         // 27 write dropped
        add(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h000, 1'b0, 1'b0, 32'h0);         // 28
        add(1'b0, 1'b1, 32'h008, 1'b1, 32'h77,        32'h004, 1'b0, 1'b0, 32'h0);         // 29
        add(1'b0, 1'b0, 32'h0,   1'b0, 32'h0,         32'h008, 1'b1, 1'b1, 32'h77);        // 30 set 2

        // Reset state
        #2;
        check_out("reset", 0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_s);
        rst_s = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            flush_s = vecs[i].flush; wr_s = vecs[i].wr; npc_s = vecs[i].npc;
            taken_s = vecs[i].taken; data_s = vecs[i].data; pc_s = vecs[i].pc;
            #1;
            check_out("vec", i, vecs[i].exp_hit, vecs[i].exp_vp, vecs[i].exp_tgt);
            @(negedge clk_s);
        end

        // Async reset between edges while a write is pending
        flush_s = 1'b0; wr_s = 1'b1; npc_s = 32'h004; taken_s = 1'b1; data_s = 32'h99;
        pc_s = 32'h008;
        #1;
        check_out("pre_rst", 0, 1'b1, 1'b1, 32'h77);
        #1 rst_s = 1'b1;
        #1;
        check_out("async_rst", 0, 1'b0, 1'b0, 32'h0);
        @(negedge clk_s);
        rst_s = 1'b0; wr_s = 1'b0; pc_s = 32'h004;
        #1;
        check_out("rst_drop_wr", 0, 1'b0, 1'b0, 32'h0);
        pc_s = 32'h008;
        #1;
        check_out("rst_clear", 0, 1'b0, 1'b0, 32'h0);

        // Write right after reset release works again
        wr_s = 1'b1; npc_s = 32'h004; taken_s = 1'b1; data_s = 32'h3C; pc_s = 32'h004;
        @(negedge clk_s);
        wr_s = 1'b0;
        #1;
        check_out("post_rst", 0, 1'b1, 1'b1, 32'h3C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
